// File: rtl/button_event_fifo.sv
// Debounces four game buttons and queues colour press events for CPU readout over MMIO.
// Define BTN_RELEASE_EV_EN to also queue release events (bit 0 = 0).
module button_event_fifo #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned DEPTH           = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   red_button,
    input  logic                   blue_button,
    input  logic                   green_button,
    input  logic                   yellow_button,
    input  logic                   rd_en,
    output logic [31:0]            rd_data,
    output logic [$clog2(DEPTH):0] count,
    output logic [3:0]             btn_level
);

    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);
    localparam logic [PtrW:0]   Full   = (PtrW + 1)'(DEPTH);

    logic [3:0] raw;
    logic [3:0] sync1_q, sync2_q;
    logic [3:0] stable_q, stable_d;
    logic [3:0] prev_q;
    logic [3:0] pend_q, pend_d;
    logic [3:0] rise;
    logic [3:0] grant_p;
    logic [CntW-1:0] cnt_q [4];
    logic [CntW-1:0] cnt_d [4];

    logic            push_req, push_press, push_ok, pop, drop, full;
    logic [1:0]      push_col;
    logic            rd_en_q;
    logic            ovf_q, ovf_d;
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [PtrW:0]   count_q, count_d;
    logic [2:0]      mem_q [DEPTH];

`ifdef BTN_RELEASE_EV_EN
    logic [3:0] rel_q, rel_d;
    logic [3:0] fall;
    logic [3:0] grant_r;
`endif

    // Bit index is the colour code: 0 red, 1 blue, 2 green, 3 yellow.
    assign raw = {yellow_button, green_button, blue_button, red_button};

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        for (int i = 0; i < 4; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                stable_d[i] = ~stable_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // Edges come from the registered level so the pending bit lands one cycle after the flip.
    assign rise = stable_q & ~prev_q;

    always_comb begin
        push_req   = 1'b0;
        push_col   = 2'b00;
        push_press = 1'b1;
        grant_p    = '0;
`ifdef BTN_RELEASE_EV_EN
        grant_r    = '0;
`endif
        for (int i = 3; i >= 0; i--) begin
            if (pend_q[i]) begin
                push_req = 1'b1;
                push_col = 2'(i);
            end
        end
`ifdef BTN_RELEASE_EV_EN
        if (!push_req) begin
            for (int i = 3; i >= 0; i--) begin
                if (rel_q[i]) begin
                    push_req   = 1'b1;
                    push_col   = 2'(i);
                    push_press = 1'b0;
                end
            end
        end
        if (push_req && !push_press) begin
            grant_r[push_col] = 1'b1;
        end
`endif
        if (push_req && push_press) begin
            grant_p[push_col] = 1'b1;
        end
    end

`ifdef BTN_RELEASE_EV_EN
    assign fall  = ~stable_q & prev_q;
    assign rel_d = (rel_q & ~grant_r) | fall;
`endif

    // A dropped event still consumes its pending bit.
    assign pend_d  = (pend_q & ~grant_p) | rise;
    assign full    = (count_q == Full);
    assign pop     = rd_en & ~rd_en_q & (count_q != '0);
    assign push_ok = push_req & (~full | pop);
    assign drop    = push_req & full & ~pop;

    always_comb begin
        ovf_d   = ovf_q;
        count_d = count_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (pop) begin
            ovf_d  = 1'b0;
            rptr_d = rptr_q + PtrW'(1);
        end else if (drop) begin
            ovf_d = 1'b1;
        end
        if (push_ok) begin
            wptr_d = wptr_q + PtrW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + (PtrW + 1)'(1);
        end else if (pop && !push_ok) begin
            count_d = count_q - (PtrW + 1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync1_q  <= '0;
            sync2_q  <= '0;
            stable_q <= '0;
            prev_q   <= '0;
            pend_q   <= '0;
            cnt_q    <= '{default: '0};
            rd_en_q  <= 1'b0;
            ovf_q    <= 1'b0;
            wptr_q   <= '0;
            rptr_q   <= '0;
            count_q  <= '0;
`ifdef BTN_RELEASE_EV_EN
            rel_q    <= '0;
`endif
        end else begin
            sync1_q  <= raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            pend_q   <= pend_d;
            cnt_q    <= cnt_d;
            rd_en_q  <= rd_en;
            ovf_q    <= ovf_d;
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            count_q  <= count_d;
`ifdef BTN_RELEASE_EV_EN
            rel_q    <= rel_d;
`endif
        end
    end

    // Storage needs no reset; it is only visible through a non-zero count.
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wptr_q] <= {push_col, push_press};
        end
    end

    always_comb begin
        rd_data = '0;
        if (count_q != '0) begin
            rd_data = {1'b1, ovf_q, 27'b0, mem_q[rptr_q]};
        end
    end

    assign count     = count_q;
    assign btn_level = stable_q;

endmodule

// File: tb/tb_button_event_fifo.sv
// Scoreboard bench for button_event_fifo with DEBOUNCE_CYCLES = 4, DEPTH = 8.
module tb_button_event_fifo;

    localparam int unsigned Deb   = 4;
    localparam int unsigned Depth = 8;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  btn;
    logic        rd_en;
    logic [31:0] rd_data;
    logic [3:0]  count;
    logic [3:0]  btn_level;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];
    logic        rd_en_prev = 1'b0;

    button_event_fifo #(
        .DEBOUNCE_CYCLES(Deb),
        .DEPTH(Depth)
    ) dut (
        .clock(clock),
        .reset(reset),
        .red_button(btn[0]),
        .blue_button(btn[1]),
        .green_button(btn[2]),
        .yellow_button(btn[3]),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .count(count),
        .btn_level(btn_level)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ev(input int col, input bit press, input bit ovf);
        logic [1:0] c;
        c = 2'(col);
        return {1'b1, ovf, 27'b0, c, press};
    endfunction

    // Monitor: a rising rd_en presents the head word, compared against the scoreboard.
    always @(negedge clock) begin
        logic [31:0] w;
        if (!reset && rd_en && !rd_en_prev) begin
            if (exp_q.size() == 0) begin
                check("pop_empty", rd_data, 32'h0);
            end else begin
                w = exp_q.pop_front();
                check("pop_word", rd_data, w);
            end
        end
        rd_en_prev = rd_en;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic pulse_read();
        rd_en = 1'b1;
        tick(1);
        rd_en = 1'b0;
        tick(1);
    endtask

    task automatic press_mask(input logic [3:0] m);
        btn = btn | m;
        tick(12);
    endtask

    task automatic release_mask(input logic [3:0] m, input bit drain);
        btn = btn & ~m;
        tick(12);
`ifdef BTN_RELEASE_EV_EN
        if (drain) begin
            for (int i = 0; i < 4; i++) begin
                if (m[i]) begin
                    exp_q.push_back(ev(i, 1'b0, 1'b0));
                    pulse_read();
                end
            end
        end
`endif
        if (drain) begin
            @(negedge clock);
            check("rel_count", 32'(count), 32'd0);
            tick(1);
        end
    endtask

    initial begin
        int n_exp;
        reset = 1'b1;
        btn   = 4'b0000;
        rd_en = 1'b0;
        tick(3);
        reset = 1'b0;
        tick(20);
        @(negedge clock);
        check("rst_rd_data", rd_data, 32'h0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_level", 32'(btn_level), 32'd0);

        // Latency: blue driven just after edge k, event visible after edge k+8.
        tick(1);
        btn[1] = 1'b1;
        tick(7);
        @(negedge clock);
        check("lat_early", rd_data, 32'h0);
        tick(1);
        @(negedge clock);
        check("lat_word", rd_data, 32'h8000_0003);
        check("lat_count", 32'(count), 32'd1);
        check("blue_level", 32'(btn_level), 32'h2);
        tick(1);
        exp_q.push_back(32'h8000_0003);
        pulse_read();
        @(negedge clock);
        check("pop_rd_data", rd_data, 32'h0);
        check("pop_count", 32'(count), 32'd0);
        tick(1);
        release_mask(4'b0010, 1'b1);

        // Red and yellow together: red first by priority.
        press_mask(4'b1001);
        @(negedge clock);
        check("dual_count", 32'(count), 32'd2);
        check("dual_head", rd_data, 32'h8000_0001);
        tick(1);
        exp_q.push_back(32'h8000_0001);
        pulse_read();
        @(negedge clock);
        check("dual_second", rd_data, 32'h8000_0007);
        check("dual_count1", 32'(count), 32'd1);
        tick(1);
        exp_q.push_back(32'h8000_0007);
        pulse_read();
        release_mask(4'b1001, 1'b1);

        // Short glitch on green is filtered.
        btn[2] = 1'b1;
        tick(3);
        btn[2] = 1'b0;
        tick(15);
        @(negedge clock);
        check("glitch_level", 32'(btn_level), 32'd0);
        check("glitch_count", 32'(count), 32'd0);
        tick(1);

        // Overflow: DEPTH+1 presses, the last dropped.
        for (int i = 0; i < Depth + 1; i++) begin
            press_mask(4'(1 << (i % 4)));
            release_mask(4'(1 << (i % 4)), 1'b0);
        end
        @(negedge clock);
        check("ovf_count", 32'(count), 32'(Depth));
        tick(1);
        for (int i = 0; i < Depth; i++) begin
`ifdef BTN_RELEASE_EV_EN
            exp_q.push_back(ev((i / 2) % 4, (i % 2) == 0, i == 0));
`else
            exp_q.push_back(ev(i % 4, 1'b1, i == 0));
`endif
            pulse_read();
        end
        @(negedge clock);
        check("ovf_drained", 32'(count), 32'd0);
        check("ovf_empty_word", rd_data, 32'h0);
        tick(1);
        pulse_read();
        @(negedge clock);
        check("empty_pop_count", 32'(count), 32'd0);
        tick(1);

        // Held rd_en pops exactly once.
        press_mask(4'b0011);
        @(negedge clock);
        check("hold_pre", 32'(count), 32'd2);
        tick(1);
        exp_q.push_back(32'h8000_0001);
        rd_en = 1'b1;
        tick(5);
        rd_en = 1'b0;
        tick(1);
        @(negedge clock);
        check("hold_count", 32'(count), 32'd1);
        check("hold_head", rd_data, 32'h8000_0003);
        tick(1);
        press_mask(4'b1100);
        @(negedge clock);
        check("pre_rst_count", 32'(count), 32'd3);
        tick(1);

        // Synchronous reset with a partly filled queue.
        reset = 1'b1;
        btn   = 4'b0000;
        exp_q.delete();
        tick(1);
        @(negedge clock);
        check("mid_rst_count", 32'(count), 32'd0);
        check("mid_rst_word", rd_data, 32'h0);
        check("mid_rst_level", 32'(btn_level), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(15);
        @(negedge clock);
        check("post_rst_count", 32'(count), 32'd0);
        tick(1);

        // Green press then release.
        press_mask(4'b0100);
        btn[2] = 1'b0;
        tick(12);
`ifdef BTN_RELEASE_EV_EN
        n_exp = 2;
`else
        n_exp = 1;
`endif
        @(negedge clock);
        check("green_count", 32'(count), 32'(n_exp));
        check("green_head", rd_data, 32'h8000_0005);
        tick(1);
        exp_q.push_back(32'h8000_0005);
`ifdef BTN_RELEASE_EV_EN
        exp_q.push_back(32'h8000_0004);
`endif
        for (int i = 0; i < n_exp; i++) begin
            pulse_read();
        end
        @(negedge clock);
        check("green_done", 32'(count), 32'd0);
        check("sb_drain", 32'(exp_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
